// File: rtl/riscv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_arb_pkg
// Description : Shared types and default widths for the I/D memory-port
//               arbiter. Defines the state encoding that records which port
//               owns the read data returned this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_arb_pkg;

  localparam int ARB_AW = 32;  // default byte-address width
  localparam int ARB_DW = 32;  // default data width

  // Owner of the read issued in the previous cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_perf_cnt
// Description : Free-running enable counter, wraps at 2^WIDTH.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous, active-low reset
//               en    - count this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module arb_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory between the fetch
//               port (i_*) and the load/store port (d_*). At most one access
//               is granted per cycle; read data returns to its owner one
//               cycle later. The D port normally wins contention, but after
//               MAX_D_RUN consecutive D grants with fetch waiting, fetch is
//               forced through.
// Ports       : clk, rst (async active-low)
//               i_req/i_addr -> i_gnt, i_rvalid, i_rdata      fetch port
//               d_req/d_we/d_be/d_addr/d_wdata
//                            -> d_gnt, d_rvalid, d_rdata      data port
//               mem_en/we/be/addr/wdata, mem_rdata            memory side
//               conflict_cnt, i_stall_cnt                     (ARB_STATS_EN)
// Config      : ARB_STATS_EN - adds contention / fetch-stall counters
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int AW        = ARB_AW,
  parameter int DW        = ARB_DW,
  parameter int MAX_D_RUN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
`ifdef ARB_STATS_EN
  output logic [31:0]     conflict_cnt,
  output logic [31:0]     i_stall_cnt,
`endif
  input  logic [DW-1:0]   mem_rdata
);

  localparam int            RW          = $clog2(MAX_D_RUN + 1);
  localparam logic [RW-1:0] C_D_RUN_MAX = RW'(MAX_D_RUN);

  arb_state_t      r_state, w_state_nxt;
  logic [RW-1:0]   r_d_run, w_d_run_nxt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_i_rdata;
  logic [DW-1:0]   r_d_rdata;
  logic            w_i_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_d_run   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_d_run <= w_d_run_nxt;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      // Keep the last delivered word so an idle port's rdata does not follow the bus
      if (r_state == I_RD) r_i_rdata <= mem_rdata;
      if (r_state == D_RD) r_d_rdata <= mem_rdata;
    end
  end

  always_comb begin
    // Fetch wins when alone, or when D has used up its consecutive-grant allowance
    w_i_win = i_req & (~d_req | (r_d_run == C_D_RUN_MAX));
    // Grants are qualified by rst so nothing reaches memory while reset is held
    i_gnt   = rst & w_i_win;
    d_gnt   = rst & d_req & ~w_i_win;

    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_be    = '0;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    if (i_gnt) begin
      mem_be   = '1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end

    // Starvation counter only tracks D grants taken while fetch is waiting
    w_d_run_nxt = r_d_run;
    if (!i_req || i_gnt) begin
      w_d_run_nxt = '0;
    end else if (d_gnt && (r_d_run != C_D_RUN_MAX)) begin
      w_d_run_nxt = r_d_run + RW'(1);
    end

    w_state_nxt = IDLE;
    if (i_gnt) begin
      w_state_nxt = I_RD;
    end else if (d_gnt && !d_we) begin
      w_state_nxt = D_RD;
    end

    i_rvalid = (r_state == I_RD);
    d_rvalid = (r_state == D_RD);
    i_rdata  = i_rvalid ? mem_rdata : r_i_rdata;
    d_rdata  = d_rvalid ? mem_rdata : r_d_rdata;
  end

`ifdef ARB_STATS_EN
  arb_perf_cnt #(.WIDTH(32)) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (i_req & d_req),
    .count (conflict_cnt)
  );

  arb_perf_cnt #(.WIDTH(32)) u_i_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (i_req & ~i_gnt),
    .count (i_stall_cnt)
  );
`endif

endmodule
`default_nettype wire
